spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter TURNAROUND, default 2: idle clk cycles between the last command bit and the first sampled MISO bit on READ_DATA frames.
REQ-002 SHALL have parameter GAP, default 1: minimum clk cycles SS_n stays high between frames.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_cmd  input  2  00 WRITE_ADDR, 01 WRITE_DATA, 10 READ_ADDR, 11 READ_DATA.
REQ-008 SHALL have port req_data  input  8  payload; don't-care for READ_DATA.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle pulse marking valid read data.
REQ-010 SHALL have port rsp_data  output  8  byte read back; held until the next rsp_valid.
REQ-011 SHALL have port busy  output  1  high from request acceptance until the end of GAP.
REQ-012 SHALL have port SS_n  output  1  slave select, active low.
REQ-013 SHALL have port MOSI  output  1  serial data to slave.
REQ-014 SHALL have port MISO  input  1  serial data from slave.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid and req_ready are both high; req_ready SHALL equal state==IDLE.
REQ-016 SHALL latch {req_cmd, req_data} as a 10-bit frame on acceptance; later input changes SHALL NOT affect the frame.
REQ-017 SHALL implement states IDLE -> CMD -> SHIFT -> (TURN -> RECV, READ_DATA only) -> GAP -> IDLE.
REQ-018 In CMD (1 cycle, first cycle after acceptance), SS_n SHALL be 0 and MOSI SHALL be req_cmd[1].
REQ-019 In SHIFT (10 cycles), SS_n SHALL be 0 and MOSI SHALL carry frame bits 9 down to 0, MSB first, one bit per cycle.
REQ-020 In TURN (TURNAROUND cycles), SS_n SHALL be 0 and MOSI SHALL be 0.
REQ-021 In RECV (8 cycles), SS_n SHALL be 0 and MISO SHALL be sampled each cycle into rsp_data, MSB first.
REQ-022 rsp_valid SHALL pulse for exactly one cycle, in the cycle after the 8th MISO sample.
REQ-023 In GAP (GAP cycles), SS_n SHALL be 1 and MOSI SHALL be 0; IDLE SHALL follow.
REQ-024 A write or READ_ADDR frame SHALL hold SS_n low for 11 cycles; a READ_DATA frame SHALL hold it low for 19+TURNAROUND cycles.
REQ-025 Minimum request-to-request spacing SHALL be 12+GAP cycles for non-READ_DATA frames.
REQ-026 Requests arriving while busy SHALL be ignored and SHALL NOT be queued.
REQ-027 The bit counter SHALL be 4 bits wide, reload on each state entry, and never wrap inside a state.
REQ-028 A READ_DATA issued without a prior READ_ADDR SHALL still run the full frame and return whatever MISO carries.

Reset
REQ-029 While rst_n=0, outputs SHALL be: SS_n=1, MOSI=0, req_ready=0, busy=0, rsp_valid=0, rsp_data=8'h00, and the state SHALL be IDLE.
REQ-030 req_ready SHALL rise on the first clk edge after rst_n returns to 1.
REQ-031 Reset asserted mid-frame SHALL force SS_n=1 on that edge with no rsp_valid pulse; the aborted frame SHALL be discarded.

Structure
REQ-032 Package spi_pkg SHALL hold the cmd enum (WRITE_ADDR..READ_DATA), the state enum, and constants FRAME_BITS=10 and DATA_BITS=8.
REQ-033 Sub-module spi_master_shifter SHALL contain the 10-bit transmit and 8-bit receive shift registers; the FSM SHALL remain in spi_master_ctrl.

Verification
REQ-034 WRITE_ADDR 8'h3C -> SS_n low for 11 cycles; MOSI sequence 0, then 0,0,0,0,1,1,1,1,0,0; no rsp_valid.
REQ-035 WRITE_ADDR 8'h3C, WRITE_DATA 8'hA5, READ_ADDR 8'h3C, READ_DATA against the attached slave/RAM -> rsp_valid pulses once with rsp_data=8'hA5.
REQ-036 READ_DATA with MISO driven 1,0,0,1,0,1,1,0 during RECV -> rsp_data=8'h96, rsp_valid pulses 20+TURNAROUND cycles after acceptance.
REQ-037 req_valid held high through a frame with a second request whose req_data changes -> exactly one frame sent; first payload intact; second accepted only after GAP.
REQ-038 rst_n=0 in SHIFT cycle 5 -> SS_n=1 on that edge, no rsp_valid, req_ready=1 one cycle after release.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Command field carried in the two MSBs of every frame
  typedef enum logic [1:0] {
    WRITE_ADDR = 2'b00,
    WRITE_DATA = 2'b01,
    READ_ADDR  = 2'b10,
    READ_DATA  = 2'b11
  } cmd_e;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TURN  = 3'd3,
    ST_RECV  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  // Only READ_DATA frames continue into a receive phase after the command bits
  function automatic logic has_recv(input cmd_e cmd);
    return (cmd == READ_DATA);
  endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Transmit (frame) and receive (byte) shift registers for the SPI master.
// Exposes next-state views so the controller can register its pin outputs
// without adding a cycle of latency.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_frame,
  input  logic                  tx_shift,
  input  logic                  rx_shift,
  input  logic                  miso,
  output logic                  tx_msb_next,
  output logic [DATA_BITS-1:0]  rx_next
);

  logic [FRAME_BITS-1:0] tx_r;
  logic [FRAME_BITS-1:0] tx_next_s;
  logic [DATA_BITS-1:0]  rx_r;
  logic [DATA_BITS-1:0]  rx_next_s;

  // Next transmit/receive contents: load wins, otherwise shift MSB-first when enabled
  always_comb begin
    tx_next_s = tx_r;
    rx_next_s = rx_r;
    if (load) begin
      tx_next_s = load_frame;
    end else if (tx_shift) begin
      tx_next_s = {tx_r[FRAME_BITS-2:0], 1'b0};
    end else begin
      tx_next_s = tx_r;
    end
    if (rx_shift) begin
      rx_next_s = {rx_r[DATA_BITS-2:0], miso};
    end else begin
      rx_next_s = rx_r;
    end
  end

  // Shift register state, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_r <= {FRAME_BITS{1'b0}};
      rx_r <= {DATA_BITS{1'b0}};
    end else begin
      tx_r <= tx_next_s;
      rx_r <= rx_next_s;
    end
  end

  assign tx_msb_next = tx_next_s[FRAME_BITS-1];
  assign rx_next     = rx_next_s;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: accepts one 10-bit command frame at a time, shifts
// it out MSB first, optionally receives a byte (READ_DATA), then holds SS_n
// high for GAP cycles. All pin outputs are registered from next-state decode.
// TURNAROUND and GAP are expected in the range 0..16 (4-bit counter).
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int TURNAROUND = 2,
  parameter int GAP        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [DATA_BITS-1:0] req_data,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam logic [3:0] SHIFT_LOAD = 4'(FRAME_BITS - 1);
  localparam logic [3:0] RECV_LOAD  = 4'(DATA_BITS - 1);
  localparam logic [3:0] TURN_LOAD  = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
  localparam logic [3:0] GAP_LOAD   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam state_e     AFTER_TX   = (GAP > 0) ? ST_GAP : ST_IDLE;
  localparam state_e     AFTER_CMD  = (TURNAROUND > 0) ? ST_TURN : ST_RECV;

  state_e              state_r;
  state_e              state_next_s;
  cmd_e                cmd_r;
  logic [3:0]          cnt_r;
  logic                accept_s;
  logic                rsp_fire_s;
  logic                tx_msb_next_s;
  logic [DATA_BITS-1:0] rx_next_s;
  logic                ss_n_s;
  logic                mosi_s;
  logic                ss_n_r;
  logic                mosi_r;
  logic                ready_r;
  logic                busy_r;
  logic                rsp_valid_r;
  logic [DATA_BITS-1:0] rsp_data_r;

  assign accept_s   = req_valid & ready_r;
  assign rsp_fire_s = (state_r == ST_RECV) && (cnt_r == 4'd0);

  spi_master_shifter u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept_s),
    .load_frame  ({req_cmd, req_data}),
    .tx_shift    (state_r == ST_SHIFT),
    .rx_shift    (state_r == ST_RECV),
    .miso        (MISO),
    .tx_msb_next (tx_msb_next_s),
    .rx_next     (rx_next_s)
  );

  // State register, latched command and per-state countdown (reloaded on every state entry)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cmd_r   <= WRITE_ADDR;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        cmd_r <= cmd_e'(req_cmd);
      end else begin
        cmd_r <= cmd_r;
      end
      if (state_next_s != state_r) begin
        case (state_next_s)
          ST_SHIFT: cnt_r <= SHIFT_LOAD;
          ST_TURN:  cnt_r <= TURN_LOAD;
          ST_RECV:  cnt_r <= RECV_LOAD;
          ST_GAP:   cnt_r <= GAP_LOAD;
          default:  cnt_r <= 4'd0;
        endcase
      end else if (cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state decode; each timed state exits when its countdown reaches zero
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_CMD;
        else          state_next_s = ST_IDLE;
      end
      ST_CMD: begin
        state_next_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_r != 4'd0)        state_next_s = ST_SHIFT;
        else if (has_recv(cmd_r)) state_next_s = AFTER_CMD;
        else                      state_next_s = AFTER_TX;
      end
      ST_TURN: begin
        if (cnt_r != 4'd0) state_next_s = ST_TURN;
        else               state_next_s = ST_RECV;
      end
      ST_RECV: begin
        if (cnt_r != 4'd0) state_next_s = ST_RECV;
        else               state_next_s = AFTER_TX;
      end
      ST_GAP: begin
        if (cnt_r != 4'd0) state_next_s = ST_GAP;
        else               state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Pin values for the state being entered; CMD repeats the frame MSB before SHIFT sends it
  always_comb begin
    ss_n_s = 1'b1;
    mosi_s = 1'b0;
    case (state_next_s)
      ST_CMD, ST_SHIFT: begin
        ss_n_s = 1'b0;
        mosi_s = tx_msb_next_s;
      end
      ST_TURN, ST_RECV: begin
        ss_n_s = 1'b0;
        mosi_s = 1'b0;
      end
      default: begin
        ss_n_s = 1'b1;
        mosi_s = 1'b0;
      end
    endcase
  end

  // Registered outputs; reset forces the bus idle and drops any in-flight response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_BITS{1'b0}};
    end else begin
      ss_n_r      <= ss_n_s;
      mosi_r      <= mosi_s;
      ready_r     <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      rsp_valid_r <= rsp_fire_s;
      if (rsp_fire_s) begin
        rsp_data_r <= rx_next_s;
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  assign SS_n      = ss_n_r;
  assign MOSI      = mosi_r;
  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a small register-file slave model.
module tb_spi_master_ctrl;

  localparam int T = 2;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       ss_n;
  logic       mosi;
  logic       miso;

  int n_checks = 0;
  int n_errors = 0;

  spi_master_ctrl #(.TURNAROUND(T), .GAP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (ss_n),
    .MOSI      (mosi),
    .MISO      (miso)
  );

  always #5 clk = ~clk;

  // Slave model state
  logic [7:0]  mem [256];
  logic [7:0]  slv_addr = 8'h00;
  logic [10:0] frame_bits = 11'h000;
  logic [10:0] last_bits = 11'h000;
  int          ss_cyc = 0;
  int          last_low_len = 0;
  int          frames = 0;
  int          rsp_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: records MOSI per low cycle, decodes the frame, drives MISO in RECV cycles
  always @(negedge clk) begin
    logic [7:0] b;
    if (rsp_valid) rsp_count++;
    miso = 1'b0;
    if (!ss_n) begin
      if (ss_cyc <= 10) frame_bits[10-ss_cyc] = mosi;
      if (ss_cyc == 10) begin
        case (frame_bits[9:8])
          2'b00:   slv_addr = frame_bits[7:0];
          2'b01:   mem[slv_addr] = frame_bits[7:0];
          2'b10:   slv_addr = frame_bits[7:0];
          default: ;
        endcase
      end
      if (frame_bits[9:8] == 2'b11 && ss_cyc >= 11 + T && ss_cyc <= 18 + T) begin
        b = mem[slv_addr];
        miso = b[7 - (ss_cyc - 11 - T)];
      end
      ss_cyc++;
    end else begin
      if (ss_cyc > 0) begin
        frames++;
        last_low_len = ss_cyc;
        last_bits = frame_bits;
      end
      ss_cyc = 0;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] data);
    wait_ready();
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_data  = data;
    @(negedge clk);
    req_valid = 1'b0;
    req_cmd   = 2'($urandom_range(3, 0));
    req_data  = 8'($urandom_range(255, 0));
  endtask

  initial begin
    int n;
    int r0;
    int f0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 2'b00; req_data = 8'h00; miso = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ss_n", {31'd0, ss_n}, 32'd1);
    check_eq("rst_mosi", {31'd0, mosi}, 32'd0);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // WRITE_ADDR 3C: 11 low cycles, MOSI 0 then 00_0011_1100, no response
    r0 = rsp_count;
    send(2'b00, 8'h3C);
    check_eq("cmd_ss_n", {31'd0, ss_n}, 32'd0);
    check_eq("cmd_busy", {31'd0, busy}, 32'd1);
    check_eq("cmd_ready", {31'd0, req_ready}, 32'd0);
    wait_idle();
    check_eq("wa_low_len", 32'(last_low_len), 32'd11);
    check_eq("wa_mosi", {21'd0, last_bits}, {21'd0, 11'b0_00_0011_1100});
    check_eq("wa_no_rsp", 32'(rsp_count), 32'(r0));

    // Write A5 then read it back through the slave
    send(2'b01, 8'hA5);
    wait_idle();
    check_eq("wd_mosi", {21'd0, last_bits}, {21'd0, 11'b0_01_1010_0101});
    send(2'b10, 8'h3C);
    wait_idle();
    check_eq("ra_mosi", {21'd0, last_bits}, {21'd0, 11'b1_10_0011_1100});
    r0 = rsp_count;
    send(2'b11, 8'h00);
    wait_idle();
    check_eq("rd_rsp_count", 32'(rsp_count), 32'(r0 + 1));
    check_eq("rd_rsp_data", {24'd0, rsp_data}, 32'h A5);
    check_eq("rd_low_len", 32'(last_low_len), 32'(19 + T));

    // READ_DATA returning 1,0,0,1,0,1,1,0 and response latency
    mem[8'h10] = 8'h96;
    send(2'b10, 8'h10);
    wait_idle();
    wait_ready();
    req_valid = 1'b1; req_cmd = 2'b11; req_data = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("rd96_latency", 32'(n), 32'(20 + T));
    check_eq("rd96_data", {24'd0, rsp_data}, 32'h96);
    @(negedge clk);
    check_eq("rd96_pulse_len", {31'd0, rsp_valid}, 32'd0);
    wait_idle();
    repeat (3) @(negedge clk);
    check_eq("rd96_hold", {24'd0, rsp_data}, 32'h96);

    // Held req_valid with changing payload: one frame, next accept after GAP
    f0 = frames;
    wait_ready();
    req_valid = 1'b1; req_cmd = 2'b00; req_data = 8'h11;
    @(negedge clk);
    req_data = 8'h22;
    n = 1;
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("spacing", 32'(n), 32'(12 + G));
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("held_frames_1", 32'(frames), 32'(f0 + 1));
    check_eq("held_payload_1", {21'd0, last_bits}, {21'd0, 11'b0_00_0001_0001});
    wait_idle();
    check_eq("held_frames_2", 32'(frames), 32'(f0 + 2));
    check_eq("held_payload_2", {21'd0, last_bits}, {21'd0, 11'b0_00_0010_0010});

    // Reset during SHIFT cycle 5 of a READ_DATA frame
    wait_ready();
    req_valid = 1'b1; req_cmd = 2'b11; req_data = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("abort_pre_ss_n", {31'd0, ss_n}, 32'd0);
    r0 = rsp_count;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_ss_n", {31'd0, ss_n}, 32'd1);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_rel", {31'd0, req_ready}, 32'd1);
    repeat (30) @(negedge clk);
    check_eq("abort_no_rsp", 32'(rsp_count), 32'(r0));
    check_eq("abort_ss_idle", {31'd0, ss_n}, 32'd1);

    // Post-abort frame runs normally
    send(2'b01, 8'h5C);
    wait_idle();
    check_eq("post_mosi", {21'd0, last_bits}, {21'd0, 11'b0_01_0101_1100});
    check_eq("post_low_len", 32'(last_low_len), 32'd11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
